fetch_stage: RTL and testbench

- Stage 0 of the 4-stage RV32I pipeline. Owns the PC and issues in-order word fetches to instruction memory over a valid/ready request channel.
- Buffers returned instructions in a small FIFO and presents them to decode as a bus_stage0 packet {instr, pc, inc_pc} with a valid/ready handshake.
- Accepts redirects (branch/jump resolution) that flush buffered instructions and discard in-flight responses.

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage of the RV32I pipeline: owns the PC, issues in-order word fetches
// to instruction memory and buffers returned instructions for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] out_bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fifo_entry_t;

  logic [31:0] pc_q, pc_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        kill_q, kill_d;
  cnt_t        fifo_cnt_q, fifo_cnt_d;
  ptr_t        pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  ptr_t        fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

  logic [31:0] pcq_mem  [DEPTH];
  fifo_entry_t fifo_mem [DEPTH];

  logic        credit;
  logic        req_fire;
  logic        resp_live;
  logic        kill_dec;
  logic        pop;
  logic [CW:0] occupancy;
  fifo_entry_t head;

  // Credit looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign credit    = occupancy < DEPTH_C;

  assign imem_req_valid = ~rst & ~redirect_valid & credit;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign resp_live = imem_resp_valid & (kill_q == '0) & ~redirect_valid;
  assign kill_dec  = imem_resp_valid & (kill_q != '0);

  assign head      = fifo_mem[fifo_rd_q];
  assign out_valid = ~rst & (fifo_cnt_q != '0) & ~redirect_valid;
  assign out_bus   = {head.instr, head.pc, head.pc + 32'd4};
  assign pop       = out_valid & out_ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    pc_d       = req_fire ? pc_q + 32'd4 : pc_q;
    inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(imem_resp_valid);
    kill_d     = kill_q - cnt_t'(kill_dec);
    fifo_cnt_d = fifo_cnt_q + cnt_t'(resp_live) - cnt_t'(pop);
    fifo_wr_d  = fifo_wr_q + AW'(resp_live);
    fifo_rd_d  = fifo_rd_q + AW'(pop);
    pcq_wr_d   = pcq_wr_q + AW'(req_fire);
    pcq_rd_d   = pcq_rd_q + AW'(imem_resp_valid);

    if (redirect_valid) begin
      // Everything still outstanding after this cycle's response becomes stale.
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      kill_d     = inflight_q - cnt_t'(imem_resp_valid);
      inflight_d = inflight_q - cnt_t'(imem_resp_valid);
      fifo_cnt_d = '0;
      fifo_rd_d  = fifo_wr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      kill_q     <= '0;
      fifo_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
    end
  end

  // NOTE: storage arrays are not reset; the reset pointers and counts mark them empty.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_mem[pcq_wr_q] <= pc_q;
    end
    if (resp_live) begin
      fifo_mem[fifo_wr_q] <= '{instr: imem_resp_data, pc: pcq_mem[pcq_rd_q]};
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a fixed-latency imem model plus per-scenario
// tasks that compare observed requests and decode packets against hand values.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_bus;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_bus         (out_bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int lat    = 1;

  typedef struct {
    logic [31:0] a;
    int          t;
  } req_t;

  req_t        q[$];
  logic [31:0] req_log[$];
  logic [95:0] pkt_log[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [95:0] pkt_of(input logic [31:0] a);
    return {instr_of(a), a, a + 32'd4};
  endfunction

  always @(posedge clk) edge_n++;

  // imem model and logger: evaluates just after each falling edge, once the
  // stimulus for the coming rising edge is in place.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      q.delete();
      imem_resp_valid = 1'b0;
    end else begin
      if (q.size() > 0 && q[0].t + lat <= edge_n + 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(q[0].a);
        void'(q.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        q.push_back('{a: imem_req_addr, t: edge_n + 1});
        req_log.push_back(imem_req_addr);
      end
      if (out_valid && out_ready) pkt_log.push_back(out_bus);
    end
  end

  task automatic do_reset(input logic rdy, input int l);
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b1; out_ready = rdy; lat = l;
    @(negedge clk);
    @(negedge clk);
    req_log.delete();
    pkt_log.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0, 1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    @(negedge clk);
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid2 got %b exp 0", imem_req_valid); end
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_first_req got %b exp 1", imem_req_valid); end
    checks++; if (imem_req_addr !== RPC) begin errors++; $display("FAIL reset_first_addr got %h exp %h", imem_req_addr, RPC); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_fifo_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_stream;
    do_reset(1'b1, 1);
    #2;
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL stream_addr0 got %h exp 00000100", imem_req_addr); end
    @(negedge clk); #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b exp 0", out_valid); end
    checks++; if (imem_req_addr !== 32'h104) begin errors++; $display("FAIL stream_addr1 got %h exp 00000104", imem_req_addr); end
    @(negedge clk); #2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid got %b exp 1", out_valid); end
    checks++; if (out_bus !== pkt_of(32'h100)) begin errors++; $display("FAIL stream_first_bus got %h exp %h", out_bus, pkt_of(32'h100)); end
    repeat (10) @(negedge clk);
    #2;
    checks++; if (req_log.size() != 13) begin errors++; $display("FAIL stream_req_count got %0d exp 13", req_log.size()); end
    checks++; if (pkt_log.size() != 11) begin errors++; $display("FAIL stream_pkt_count got %0d exp 11", pkt_log.size()); end
    for (int i = 0; i < req_log.size(); i++) begin
      checks++; if (req_log[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL stream_req[%0d] got %h exp %h", i, req_log[i], 32'h100 + 32'(4 * i)); end
    end
    for (int i = 0; i < pkt_log.size(); i++) begin
      checks++; if (pkt_log[i] !== pkt_of(32'h100 + 32'(4 * i))) begin errors++; $display("FAIL stream_pkt[%0d] got %h exp %h", i, pkt_log[i], pkt_of(32'h100 + 32'(4 * i))); end
    end
  endtask

  task automatic test_stall;
    do_reset(1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++; if (out_valid !== (i >= 2)) begin errors++; $display("FAIL stall_valid[%0d] got %b exp %b", i, out_valid, (i >= 2)); end
      if (i >= 2) begin
        checks++; if (out_bus !== pkt_of(32'h100)) begin errors++; $display("FAIL stall_bus[%0d] got %h exp %h", i, out_bus, pkt_of(32'h100)); end
      end
      @(negedge clk);
    end
    checks++; if (req_log.size() != 4) begin errors++; $display("FAIL stall_req_count got %0d exp 4", req_log.size()); end
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    checks++; if (pkt_log.size() != 9) begin errors++; $display("FAIL stall_drain_count got %0d exp 9", pkt_log.size()); end
    for (int i = 0; i < pkt_log.size(); i++) begin
      checks++; if (pkt_log[i] !== pkt_of(32'h100 + 32'(4 * i))) begin errors++; $display("FAIL stall_drain[%0d] got %h exp %h", i, pkt_log[i], pkt_of(32'h100 + 32'(4 * i))); end
    end
  endtask

  task automatic test_redirect;
    do_reset(1'b1, 3);
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_blocked got %b exp 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL redir_addr got %h exp 00000200", imem_req_addr); end
    repeat (12) @(negedge clk);
    #2;
    checks++; if (req_log.size() < 3 || req_log[2] !== 32'h200) begin errors++; $display("FAIL redir_req_log got size %0d exp third addr 00000200", req_log.size()); end
    checks++; if (pkt_log.size() < 3) begin errors++; $display("FAIL redir_pkt_count got %0d exp >=3", pkt_log.size()); end
    for (int i = 0; i < pkt_log.size(); i++) begin
      checks++; if (pkt_log[i] !== pkt_of(32'h200 + 32'(4 * i))) begin errors++; $display("FAIL redir_pkt[%0d] got %h exp %h", i, pkt_log[i], pkt_of(32'h200 + 32'(4 * i))); end
    end
  endtask

  task automatic test_redirect_resp;
    do_reset(1'b1, 1);
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    #2;
    checks++; if (imem_resp_valid !== 1'b1) begin errors++; $display("FAIL rr_resp_present got %b exp 1", imem_resp_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_out_valid got %b exp 0", out_valid); end
    checks++; if (pkt_log.size() != 0) begin errors++; $display("FAIL rr_no_pop got %0d exp 0", pkt_log.size()); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    checks++; if (imem_req_addr !== 32'h300) begin errors++; $display("FAIL rr_addr got %h exp 00000300", imem_req_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_flushed got %b exp 0", out_valid); end
    repeat (6) @(negedge clk);
    #2;
    checks++; if (pkt_log.size() < 3) begin errors++; $display("FAIL rr_pkt_count got %0d exp >=3", pkt_log.size()); end
    for (int i = 0; i < pkt_log.size(); i++) begin
      checks++; if (pkt_log[i] !== pkt_of(32'h300 + 32'(4 * i))) begin errors++; $display("FAIL rr_pkt[%0d] got %h exp %h", i, pkt_log[i], pkt_of(32'h300 + 32'(4 * i))); end
    end
  endtask

  task automatic test_back_to_back;
    int ridx;
    int pidx;
    logic [31:0] targets [3];
    targets[0] = 32'h40; targets[1] = 32'h80; targets[2] = 32'hC0;
    do_reset(1'b1, 2);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      redirect_valid = 1'b1; redirect_pc = targets[i];
      #2;
      if (i == 0) begin
        ridx = req_log.size();
        pidx = pkt_log.size();
      end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_req_blocked[%0d] got %b exp 0", i, imem_req_valid); end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    #2;
    checks++; if (imem_req_addr !== 32'hC0) begin errors++; $display("FAIL b2b_addr got %h exp 000000c0", imem_req_addr); end
    repeat (10) @(negedge clk);
    #2;
    checks++; if (req_log.size() <= ridx || req_log[ridx] !== 32'hC0) begin errors++; $display("FAIL b2b_first_req got size %0d exp first addr 000000c0", req_log.size()); end
    checks++; if (pkt_log.size() < pidx + 3) begin errors++; $display("FAIL b2b_pkt_count got %0d exp >=%0d", pkt_log.size(), pidx + 3); end
    for (int i = pidx; i < pkt_log.size(); i++) begin
      checks++; if (pkt_log[i] !== pkt_of(32'hC0 + 32'(4 * (i - pidx)))) begin errors++; $display("FAIL b2b_pkt[%0d] got %h exp %h", i, pkt_log[i], pkt_of(32'hC0 + 32'(4 * (i - pidx)))); end
    end
  endtask

  task automatic test_wrap;
    do_reset(1'b1, 1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_req_blocked got %b exp 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got %h exp fffffffc", imem_req_addr); end
    @(negedge clk); #2;
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h exp 00000000", imem_req_addr); end
    @(negedge clk); #2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", out_valid); end
    checks++; if (out_bus !== {instr_of(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0}) begin errors++; $display("FAIL wrap_bus0 got %h exp %h", out_bus, {instr_of(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0}); end
    @(negedge clk); #2;
    checks++; if (out_bus !== {instr_of(32'h0), 32'h0, 32'h4}) begin errors++; $display("FAIL wrap_bus1 got %h exp %h", out_bus, {instr_of(32'h0), 32'h0, 32'h4}); end
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    out_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_redirect_resp;
    test_back_to_back;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
